// File: rtl/snake_body_if.sv
// Bus bundle between the snake body streamer (slave) and the game logic / renderer side (master).
`ifndef SNAKE_LENGTH_BIT
`define SNAKE_LENGTH_BIT 5
`endif

interface snake_body_if #(
    parameter int LENGTH_BIT = `SNAKE_LENGTH_BIT
);
    logic                  move_tick;
    logic                  grow;
    logic [6:0]            snake_head_x;
    logic [6:0]            snake_head_y;
    logic                  frame_start;
    logic [6:0]            snake_body_x;
    logic [6:0]            snake_body_y;
    logic                  en_snake_body;
    logic [LENGTH_BIT-1:0] snake_length;
    logic                  self_collision;

    modport master (
        output move_tick, grow, snake_head_x, snake_head_y, frame_start,
        input  snake_body_x, snake_body_y, en_snake_body, snake_length, self_collision
    );

    modport slave (
        input  move_tick, grow, snake_head_x, snake_head_y, frame_start,
        output snake_body_x, snake_body_y, en_snake_body, snake_length, self_collision
    );
endinterface

// File: rtl/snake_body_streamer.sv
// Snake body segment store: shifts on move ticks, streams one segment per clock each frame.
// Optional head-vs-body check enabled by defining SNAKE_SELF_COLLISION_EN.
`ifndef SNAKE_LENGTH_MAX
`define SNAKE_LENGTH_MAX 16
`endif
`ifndef SNAKE_LENGTH_BIT
`define SNAKE_LENGTH_BIT 5
`endif

// state | meaning
// IDLE  | waiting; moves are applied here, frame requests start a stream
// SEND  | streaming seg[0..L-1], one segment per clock, en_snake_body high
module snake_body_streamer #(
    parameter int LENGTH_MAX  = `SNAKE_LENGTH_MAX,
    parameter int LENGTH_BIT  = `SNAKE_LENGTH_BIT,
    parameter int INIT_LENGTH = 3,
    parameter int INIT_X      = 20,
    parameter int INIT_Y      = 40
) (
    input  logic         clock_25,
    input  logic         reset,
    snake_body_if.slave  bus
);
    localparam int IDX_W = (LENGTH_MAX > 1) ? $clog2(LENGTH_MAX) : 1;
    localparam logic [LENGTH_BIT-1:0] LEN_MAX_V  = LENGTH_BIT'(LENGTH_MAX);
    localparam logic [LENGTH_BIT-1:0] LEN_INIT_V = LENGTH_BIT'(INIT_LENGTH);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;

    logic [6:0]            seg_x [LENGTH_MAX];
    logic [6:0]            seg_y [LENGTH_MAX];
    logic [6:0]            head_x, head_y;
    logic [LENGTH_BIT-1:0] len_q, send_len, k;
    logic                  move_pend, pend_grow, frame_pend;
    logic [6:0]            pend_x, pend_y;
    logic [6:0]            body_x, body_y;
    logic                  en_q;

    logic                  do_move, start_send, last_seg, mv_grow, grow_ok;
    logic [6:0]            mv_x, mv_y;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A fresh move_tick wins over a pending one.
    always_comb begin
        state_nxt  = state;
        do_move    = 1'b0;
        start_send = 1'b0;
        last_seg   = 1'b0;
        mv_grow    = bus.move_tick ? bus.grow         : pend_grow;
        mv_x       = bus.move_tick ? bus.snake_head_x : pend_x;
        mv_y       = bus.move_tick ? bus.snake_head_y : pend_y;
        grow_ok    = mv_grow && (len_q < LEN_MAX_V);
        case (state)
            IDLE: begin
                do_move = bus.move_tick | move_pend;
                if (!do_move && (bus.frame_start | frame_pend)) begin
                    start_send = 1'b1;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                last_seg = (k == send_len);
                if (last_seg) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LENGTH_MAX; i++) begin
                seg_x[i] <= (i < INIT_LENGTH) ? 7'(INIT_X - 1 - i) : 7'd0;
                seg_y[i] <= (i < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
            end
            head_x     <= 7'(INIT_X);
            head_y     <= 7'(INIT_Y);
            len_q      <= LEN_INIT_V;
            send_len   <= '0;
            k          <= '0;
            move_pend  <= 1'b0;
            pend_grow  <= 1'b0;
            pend_x     <= 7'd0;
            pend_y     <= 7'd0;
            frame_pend <= 1'b0;
            body_x     <= 7'd0;
            body_y     <= 7'd0;
            en_q       <= 1'b0;
        end else begin
            if (do_move) begin
                for (int i = 1; i < LENGTH_MAX; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0]   <= head_x;
                seg_y[0]   <= head_y;
                head_x     <= mv_x;
                head_y     <= mv_y;
                if (grow_ok) len_q <= len_q + 1'b1;
                move_pend  <= 1'b0;
                frame_pend <= bus.frame_start | frame_pend;
            end else if (state == SEND && bus.move_tick) begin
                move_pend <= 1'b1;
                pend_grow <= bus.grow;
                pend_x    <= bus.snake_head_x;
                pend_y    <= bus.snake_head_y;
            end
            if (start_send) begin
                send_len   <= len_q;
                k          <= LENGTH_BIT'(1);
                body_x     <= seg_x[0];
                body_y     <= seg_y[0];
                en_q       <= 1'b1;
                frame_pend <= 1'b0;
            end else if (state == SEND) begin
                if (last_seg) begin
                    en_q <= 1'b0;
                end else begin
                    body_x <= seg_x[k[IDX_W-1:0]];
                    body_y <= seg_y[k[IDX_W-1:0]];
                    k      <= k + 1'b1;
                end
            end
        end
    end

    assign bus.snake_body_x  = body_x;
    assign bus.snake_body_y  = body_y;
    assign bus.en_snake_body = en_q;
    assign bus.snake_length  = len_q;

`ifdef SNAKE_SELF_COLLISION_EN
    logic                  hit, coll_q;
    logic [LENGTH_BIT-1:0] m_cnt;

    // Without growth the tail block is vacated by this move, so it is excluded.
    always_comb begin
        m_cnt = grow_ok ? len_q : len_q - 1'b1;
        hit   = 1'b0;
        for (int i = 0; i < LENGTH_MAX; i++) begin
            if ((i < int'(m_cnt)) && (seg_x[i] == mv_x) && (seg_y[i] == mv_y)) hit = 1'b1;
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset)                coll_q <= 1'b0;
        else if (do_move && hit)  coll_q <= 1'b1;
    end

    assign bus.self_collision = coll_q;
`else
    assign bus.self_collision = 1'b0;
`endif
endmodule

// File: tb/tb_snake_body_streamer.sv
// Bench for snake_body_streamer: directed and randomized moves/frames against a list-based reference model.
`ifndef SNAKE_LENGTH_MAX
`define SNAKE_LENGTH_MAX 16
`endif
`ifndef SNAKE_LENGTH_BIT
`define SNAKE_LENGTH_BIT 5
`endif

module tb_snake_body_streamer;
    localparam int LMAX = `SNAKE_LENGTH_MAX;
    localparam int LB   = `SNAKE_LENGTH_BIT;
`ifdef SNAKE_SELF_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic clock_25 = 1'b0;
    logic reset;
    always #20 clock_25 = ~clock_25;

    snake_body_if #(.LENGTH_BIT(LB)) bus ();

    snake_body_streamer #(
        .LENGTH_MAX(LMAX), .LENGTH_BIT(LB), .INIT_LENGTH(3), .INIT_X(20), .INIT_Y(40)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: body as a list, head kept apart, list front is next to the head.
    int mq_x[$];
    int mq_y[$];
    int mhx, mhy;
    bit mcoll;

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_x.delete();
        mq_y.delete();
        for (int i = 0; i < 3; i++) begin
            mq_x.push_back(19 - i);
            mq_y.push_back(40);
        end
        mhx   = 20;
        mhy   = 40;
        mcoll = 1'b0;
    endtask

    task automatic model_move(input int hx, input int hy, input bit g);
        int  n;
        bit  gr;
        int  m;
        n  = mq_x.size();
        gr = g && (n < LMAX);
        m  = gr ? n : n - 1;
        for (int i = 0; i < m; i++)
            if (COLL_EN && mq_x[i] == hx && mq_y[i] == hy) mcoll = 1'b1;
        mq_x.push_front(mhx);
        mq_y.push_front(mhy);
        mhx = hx;
        mhy = hy;
        if (!gr) begin
            void'(mq_x.pop_back());
            void'(mq_y.pop_back());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        chk("rst_en", bus.en_snake_body, 0);
        chk("rst_len", bus.snake_length, 3);
        chk("rst_coll", bus.self_collision, 0);
        chk("rst_bx", bus.snake_body_x, 0);
    endtask

    task automatic do_move(input string tag, input int hx, input int hy, input bit g);
        bus.move_tick    = 1'b1;
        bus.grow         = g;
        bus.snake_head_x = 7'(hx);
        bus.snake_head_y = 7'(hy);
        model_move(hx, hy, g);
        step();
        bus.move_tick = 1'b0;
        bus.grow      = 1'b0;
        chk({tag, "_len"}, bus.snake_length, mq_x.size());
        chk({tag, "_coll"}, bus.self_collision, mcoll);
    endtask

    // Called in the first cycle en_snake_body should be high.
    task automatic body_loop(input string tag, input int mv_at, input int hx, input int hy,
                             input bit g, input int fr_at);
        int L;
        L = mq_x.size();
        for (int k = 0; k < L; k++) begin
            chk({tag, "_en"}, bus.en_snake_body, 1);
            chk({tag, "_x"}, bus.snake_body_x, mq_x[k]);
            chk({tag, "_y"}, bus.snake_body_y, mq_y[k]);
            chk({tag, "_slen"}, bus.snake_length, L);
            if (k == mv_at) begin
                bus.move_tick    = 1'b1;
                bus.grow         = g;
                bus.snake_head_x = 7'(hx);
                bus.snake_head_y = 7'(hy);
            end
            if (k == fr_at) bus.frame_start = 1'b1;
            step();
            bus.move_tick   = 1'b0;
            bus.grow        = 1'b0;
            bus.frame_start = 1'b0;
        end
        chk({tag, "_endlo"}, bus.en_snake_body, 0);
        chk({tag, "_endlen"}, bus.snake_length, L);
        if (mv_at >= 0) begin
            model_move(hx, hy, g);
            step();
            chk({tag, "_pendlen"}, bus.snake_length, mq_x.size());
            chk({tag, "_pendcoll"}, bus.self_collision, mcoll);
        end
        step();
        chk({tag, "_idle"}, bus.en_snake_body, 0);
    endtask

    task automatic stream(input string tag, input int mv_at, input int hx, input int hy,
                          input bit g, input int fr_at);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        body_loop(tag, mv_at, hx, hy, g, fr_at);
    endtask

    task automatic frame_with_move(input string tag, input int hx, input int hy, input bit g);
        bus.frame_start  = 1'b1;
        bus.move_tick    = 1'b1;
        bus.grow         = g;
        bus.snake_head_x = 7'(hx);
        bus.snake_head_y = 7'(hy);
        model_move(hx, hy, g);
        step();
        bus.frame_start = 1'b0;
        bus.move_tick   = 1'b0;
        bus.grow        = 1'b0;
        chk({tag, "_gap"}, bus.en_snake_body, 0);
        chk({tag, "_len"}, bus.snake_length, mq_x.size());
        step();
        body_loop(tag, -1, 0, 0, 1'b0, -1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.move_tick    = 1'b0;
        bus.grow         = 1'b0;
        bus.snake_head_x = 7'd0;
        bus.snake_head_y = 7'd0;
        bus.frame_start  = 1'b0;
        model_reset();

        apply_reset();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("init_first_x", bus.snake_body_x, 19);
        chk("init_first_y", bus.snake_body_y, 40);
        body_loop("init", -1, 0, 0, 1'b0, -1);

        do_move("mv1", 21, 40, 1'b0);
        stream("mv1_s", -1, 0, 0, 1'b0, -1);

        apply_reset();
        do_move("grow1", 21, 40, 1'b1);
        chk("grow1_len4", bus.snake_length, 4);
        stream("grow1_s", -1, 0, 0, 1'b0, -1);

        apply_reset();
        stream("midmv", 1, 21, 40, 1'b1, -1);
        stream("midmv_post", -1, 0, 0, 1'b0, 1);

        apply_reset();
        do_move("tail", 17, 40, 1'b0);
        chk("tail_nocoll", bus.self_collision, 0);

        apply_reset();
        do_move("c_grow", 21, 40, 1'b1);
        do_move("c_hit", 19, 40, 1'b0);
        chk("c_hit_coll", bus.self_collision, COLL_EN ? 1 : 0);
        do_move("c_sticky", 30, 30, 1'b0);
        chk("c_sticky_coll", bus.self_collision, COLL_EN ? 1 : 0);

        apply_reset();
        for (int i = 0; i < LMAX + 2; i++)
            do_move("sat", 50 + i, 10, 1'b1);
        chk("sat_len", bus.snake_length, LMAX);
        stream("sat_s", -1, 0, 0, 1'b0, -1);

        apply_reset();
        frame_with_move("fm", 21, 41, 1'b1);

        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("async_en", bus.en_snake_body, 0);
        chk("async_bx", bus.snake_body_x, 0);
        step();
        reset = 1'b0;
        model_reset();
        step();
        stream("post_rst", -1, 0, 0, 1'b0, -1);

        for (int it = 0; it < 40; it++) begin
            int  mode, hx, hy, gap;
            bit  g;
            mode = $urandom_range(0, 3);
            hx   = $urandom_range(15, 24);
            hy   = $urandom_range(38, 42);
            g    = ($urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 3);
            case (mode)
                0: begin
                    do_move("r_mv", hx, hy, g);
                    repeat (gap) step();
                    stream("r_s", -1, 0, 0, 1'b0, -1);
                end
                1: stream("r_mid", $urandom_range(0, mq_x.size() - 1), hx, hy, g, -1);
                2: frame_with_move("r_fm", hx, hy, g);
                default: begin
                    repeat (gap) step();
                    stream("r_fr", -1, 0, 0, 1'b0, $urandom_range(0, mq_x.size() - 1));
                end
            endcase
            if ($urandom_range(0, 9) == 0) apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
